execute_lane_sequencer: RTL and testbench
=========================================

Name: execute_lane_sequencer

Overview:
- Converts one full-width execute request (`NUM_THREADS` lanes) into `NUM_PACKETS` = `NUM_THREADS`/`NUM_LANES` narrow packets for a `NUM_LANES`-wide functional unit.
- Generates per-packet `pid`, `sop` and `eop`.
- Sits between the dispatch stage and a narrow ALU/FPU/LSU lane group.
- Valid/ready on both sides; single holding register plus a registered output stage.

Parameters:
- `NUM_LANES`, default 4: output lane count; must divide `NUM_THREADS`; power of two.
- `NUM_PACKETS`, default `NUM_THREADS`/`NUM_LANES`: derived, not overridable.
- `PID_WIDTH`, default `LOG2UP(NUM_PACKETS)`: packet-id width; minimum 1.

Ports:
- `clk`: in, 1. Clock.
- `reset`: in, 1. Synchronous, active-high.
- `in_valid`: in, 1. Full-width request valid.
- `in_data`: in, `$bits(exec_full_t)`. Fields: uuid, wid, tmask[`NUM_THREADS`], op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, tid, rs1/rs2/rs3_data[`NUM_THREADS`][`XLEN`].
- `in_ready`: out, 1. Request accepted.
- `out_valid`: out, 1. Narrow packet valid.
- `out_data`: out, `$bits(exec_lane_t)`. Scalar fields as input; tmask and rs*_data sliced to `NUM_LANES`; plus pid, sop, eop.
- `out_ready`: in, 1. Downstream accepts packet.
- `busy`: out, 1. Holding register occupied.

Behaviour:
- Reset values:
  - State IDLE.
  - `out_valid`=0, `busy`=0, `in_ready`=1.
  - `out_data` scalar fields = 0; `pid` = 0.
- States:
  - IDLE: no held request.
  - BUSY: held request; packets being emitted.
- `in_ready` = (state==IDLE) || (`out_valid` && `out_ready` && `out_data.eop`). This gives back-to-back requests with no bubble.
- Capture: when `in_valid` && `in_ready`:
  - `in_data` latches into the holding register.
  - Packet cursor set to the first packet to emit; state moves to BUSY.
  - `out_valid` rises next cycle. Latency is 1 cycle from accept to first packet.
- Packet k content:
  - tmask = tmask[k*`NUM_LANES` +: `NUM_LANES`]; rs*_data sliced the same way.
  - pid = k.
  - sop = first emitted packet; eop = last emitted packet.
  - Scalar fields copied unchanged, including tid.
- Output is a stall-hold register:
  - While `out_valid` && !`out_ready`, `out_data` and `out_valid` hold stable.
  - On handshake, the next packet loads the following cycle.
  - When eop is accepted, the next request loads in the same cycle if `in_valid`; otherwise state goes to IDLE and `out_valid` drops.
- `NUM_PACKETS`==1 (`NUM_LANES`==`NUM_THREADS`):
  - Pass-through with 1-cycle register.
  - sop=eop=1, pid=0 every packet.
- Cursor arithmetic: unsigned `PID_WIDTH`; never wraps past `NUM_PACKETS`-1; eop asserted on the last index.
- `in_data` is don't-care when `in_valid`=0. The input is never sampled while BUSY, except on the eop-handshake cycle.
- Reset mid-operation: held request discarded, `out_valid`=0 next cycle, no partial packet re-emitted.
- `busy` = (state==BUSY).

Optional Feature:
- Macro: `EXEC_SEQ_SKIP_EMPTY_EN`.
- Defined:
  - Packets whose tmask slice is all-zero are not emitted.
  - First/next packet = lowest non-zero slice index above the cursor; sop/eop refer to emitted packets only; pid keeps the true slice index.
  - If the whole input tmask is zero, exactly one packet is emitted: pid=0, sop=eop=1, tmask=0.
- Undefined: all `NUM_PACKETS` packets are always emitted in order 0..`NUM_PACKETS`-1, including all-zero slices.

Decomposition:
- Package `execute_seq_pkg`:
  - Types `exec_full_t` and `exec_lane_t`.
  - Localparams `NUM_PACKETS` and `PID_WIDTH`.
  - Function `slice_any(tmask, k)`.
- Sub-module `execute_slice_finder`:
  - Combinational.
  - Inputs: per-slice non-zero mask and cursor.
  - Outputs: next index, valid, and is-last flag.
  - Used only when `EXEC_SEQ_SKIP_EMPTY_EN` is defined; tied to cursor+1 otherwise.

Test Plan:
- `NUM_THREADS`=16, `NUM_LANES`=4, tmask=FFFF, `out_ready`=1:
  - 4 packets pid 0..3 on consecutive cycles starting 1 cycle after accept.
  - sop only on pid0, eop only on pid3.
  - rs1 slices correct.
- Back-pressure: `out_ready` low for 3 cycles on pid1 → pid1 data held bit-stable, `in_ready`=0 throughout, then pid2 follows the cycle after release.
- Back-to-back: two requests with `in_valid` held → second request's pid0 appears the cycle after first's eop handshake, no bubble.
- `EXEC_SEQ_SKIP_EMPTY_EN`, tmask=0F00:
  - Single packet, pid=2, sop=eop=1, tmask=F.
  - With tmask=0000: single packet, pid=0, tmask=0.
- Reset asserted while pid1 is pending → `out_valid`=0 next cycle, `in_ready`=1, no stale packet after reset release.
- `NUM_LANES`=`NUM_THREADS`: every request yields one packet, pid=0, sop=eop=1, 1-cycle latency, full throughput.

Source files
------------

// File: rtl/execute_seq_pkg.sv
// Types, geometry and helpers for the execute lane sequencer.
// Geometry is fixed here so both exec_full_t and exec_lane_t agree with the top.
package execute_seq_pkg;

  localparam int NUM_THREADS = 16;
  localparam int NUM_LANES   = 4;
  localparam int XLEN        = 32;
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int UUID_W      = 16;
  localparam int WID_W       = 2;
  localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef struct packed {
    logic [UUID_W-1:0]                   uuid;
    logic [WID_W-1:0]                    wid;
    logic [NUM_THREADS-1:0]              tmask;
    logic [3:0]                          op_type;
    logic [2:0]                          op_mod;
    logic                                wb;
    logic                                use_PC;
    logic                                use_imm;
    logic [XLEN-1:0]                     PC;
    logic [XLEN-1:0]                     imm;
    logic [4:0]                          rd;
    logic [TID_W-1:0]                    tid;
    logic [NUM_THREADS-1:0][XLEN-1:0]    rs1_data;
    logic [NUM_THREADS-1:0][XLEN-1:0]    rs2_data;
    logic [NUM_THREADS-1:0][XLEN-1:0]    rs3_data;
  } exec_full_t;

  typedef struct packed {
    logic [UUID_W-1:0]                   uuid;
    logic [WID_W-1:0]                    wid;
    logic [NUM_LANES-1:0]                tmask;
    logic [3:0]                          op_type;
    logic [2:0]                          op_mod;
    logic                                wb;
    logic                                use_PC;
    logic                                use_imm;
    logic [XLEN-1:0]                     PC;
    logic [XLEN-1:0]                     imm;
    logic [4:0]                          rd;
    logic [TID_W-1:0]                    tid;
    logic [NUM_LANES-1:0][XLEN-1:0]      rs1_data;
    logic [NUM_LANES-1:0][XLEN-1:0]      rs2_data;
    logic [NUM_LANES-1:0][XLEN-1:0]      rs3_data;
    logic [PID_WIDTH-1:0]                pid;
    logic                                sop;
    logic                                eop;
  } exec_lane_t;

  function automatic logic slice_any(logic [NUM_THREADS-1:0] tmask, int k);
    return |tmask[k*NUM_LANES +: NUM_LANES];
  endfunction

  function automatic exec_lane_t make_packet(exec_full_t s, logic [PID_WIDTH-1:0] k,
                                             logic sop, logic eop);
    exec_lane_t p;
    p.uuid     = s.uuid;
    p.wid      = s.wid;
    p.tmask    = s.tmask[int'(k)*NUM_LANES +: NUM_LANES];
    p.op_type  = s.op_type;
    p.op_mod   = s.op_mod;
    p.wb       = s.wb;
    p.use_PC   = s.use_PC;
    p.use_imm  = s.use_imm;
    p.PC       = s.PC;
    p.imm      = s.imm;
    p.rd       = s.rd;
    p.tid      = s.tid;
    p.rs1_data = s.rs1_data[int'(k)*NUM_LANES +: NUM_LANES];
    p.rs2_data = s.rs2_data[int'(k)*NUM_LANES +: NUM_LANES];
    p.rs3_data = s.rs3_data[int'(k)*NUM_LANES +: NUM_LANES];
    p.pid      = k;
    p.sop      = sop;
    p.eop      = eop;
    return p;
  endfunction

endpackage

// File: rtl/execute_slice_finder.sv
// Finds the lowest non-empty slice above the cursor (or from 0 when first).
// Only compiled when EXEC_SEQ_SKIP_EMPTY_EN is defined.
`ifdef EXEC_SEQ_SKIP_EMPTY_EN
module execute_slice_finder
  import execute_seq_pkg::*;
(
  input  logic [NUM_PACKETS-1:0] nz,
  input  logic [PID_WIDTH-1:0]   cursor,
  input  logic                   first,
  output logic [PID_WIDTH-1:0]   next_idx,
  output logic                   found,
  output logic                   is_last
);

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    is_last  = 1'b1;
    // Descending scan so the lowest qualifying index wins.
    for (int i = NUM_PACKETS - 1; i >= 0; i--) begin
      if (nz[i] && (first || PID_WIDTH'(i) > cursor)) begin
        next_idx = PID_WIDTH'(i);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_PACKETS; j++) begin
      if (nz[j] && PID_WIDTH'(j) > next_idx) is_last = 1'b0;
    end
  end

endmodule
`endif

// File: rtl/execute_lane_sequencer.sv
// Splits a full-width execute request into NUM_PACKETS narrow lane packets.
// EXEC_SEQ_SKIP_EMPTY_EN: drop packets whose tmask slice is all zero.
module execute_lane_sequencer
  import execute_seq_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [$bits(exec_full_t)-1:0] in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [$bits(exec_lane_t)-1:0] out_data,
  input  logic                          out_ready,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  exec_full_t           in_s, held;
  exec_lane_t           out_q, cap_pkt, adv_pkt;
  logic [PID_WIDTH-1:0] cursor, cap_idx, adv_idx;
  logic                 cap_last, adv_last, accept, hs;

  assign in_s     = in_data;
  assign out_data = out_q;
  assign busy     = (state == BUSY);
  assign hs       = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (hs && out_q.eop);
  assign accept   = in_valid && in_ready;

`ifdef EXEC_SEQ_SKIP_EMPTY_EN
  logic [NUM_PACKETS-1:0] cap_nz, held_nz;
  logic [PID_WIDTH-1:0]   cap_nxt;
  logic                   cap_found, cap_is_last, adv_found;

  for (genvar k = 0; k < NUM_PACKETS; k++) begin : g_nz
    assign cap_nz[k]  = slice_any(in_s.tmask, k);
    assign held_nz[k] = slice_any(held.tmask, k);
  end

  execute_slice_finder u_cap_find (
    .nz(cap_nz), .cursor('0), .first(1'b1),
    .next_idx(cap_nxt), .found(cap_found), .is_last(cap_is_last)
  );

  execute_slice_finder u_adv_find (
    .nz(held_nz), .cursor(cursor), .first(1'b0),
    .next_idx(adv_idx), .found(adv_found), .is_last(adv_last)
  );

  // An all-zero request still produces one empty packet at pid 0.
  assign cap_idx  = cap_found ? cap_nxt : '0;
  assign cap_last = cap_found ? cap_is_last : 1'b1;
`else
  assign cap_idx  = '0;
  assign cap_last = (NUM_PACKETS == 1);
  assign adv_idx  = cursor + 1'b1;
  assign adv_last = (adv_idx == PID_WIDTH'(NUM_PACKETS - 1));
`endif

  assign cap_pkt = make_packet(in_s, cap_idx, 1'b1, cap_last);
  assign adv_pkt = make_packet(held, adv_idx, 1'b0, adv_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_q     <= '0;
      held      <= '0;
      cursor    <= '0;
    end else if (accept) begin
      // Covers both idle capture and the no-bubble reload on eop handshake.
      held      <= in_s;
      state     <= BUSY;
      out_valid <= 1'b1;
      out_q     <= cap_pkt;
      cursor    <= cap_idx;
    end else if (hs) begin
      if (out_q.eop) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        out_q  <= adv_pkt;
        cursor <= adv_idx;
      end
    end
  end

endmodule

// File: tb/tb_execute_lane_sequencer.sv
// Directed bench for execute_lane_sequencer (16 threads, 4 lanes).
// Vector table covers packet splitting; hand sequences cover stalls, back-to-back and reset.
module tb_execute_lane_sequencer;
  import execute_seq_pkg::*;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [$bits(exec_full_t)-1:0] in_data = '0;
  logic [$bits(exec_lane_t)-1:0] out_data;
  exec_lane_t od;
  int tests = 0, fails = 0;

  assign od = out_data;

  execute_lane_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tmask;
    int n;
    int pid[4];
    int tm[4];
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exec_full_t mk_req(input int uuid, input int tmask);
    exec_full_t r;
    r          = '0;
    r.uuid     = UUID_W'(uuid);
    r.wid      = 2'd2;
    r.tmask    = NUM_THREADS'(tmask);
    r.op_type  = 4'h5;
    r.op_mod   = 3'h3;
    r.wb       = 1'b1;
    r.PC       = 32'h8000_0000 + uuid;
    r.imm      = 32'h0000_0123;
    r.rd       = 5'd7;
    r.tid      = 4'd3;
    for (int t = 0; t < NUM_THREADS; t++) begin
      r.rs1_data[t] = 32'h1000_0000 | (uuid << 8) | t;
      r.rs2_data[t] = 32'h2000_0000 | (uuid << 8) | t;
      r.rs3_data[t] = 32'h3000_0000 | (uuid << 8) | t;
    end
    return r;
  endfunction

  task automatic chk_pkt(input int uuid, input int pid, input int sop, input int eop,
                         input int tm);
    chk("out_valid", out_valid, 1);
    chk("busy", busy, 1);
    chk("pid", od.pid, pid);
    chk("sop", od.sop, sop);
    chk("eop", od.eop, eop);
    chk("tmask", od.tmask, tm);
    chk("uuid", od.uuid, uuid);
    chk("tid", od.tid, 3);
    chk("PC", od.PC, 32'h8000_0000 + uuid);
    chk("rs1_lane0", od.rs1_data[0], 32'h1000_0000 | (uuid << 8) | (pid * 4));
    chk("rs1_lane3", od.rs1_data[3], 32'h1000_0000 | (uuid << 8) | (pid * 4 + 3));
    chk("rs3_lane2", od.rs3_data[2], 32'h3000_0000 | (uuid << 8) | (pid * 4 + 2));
  endtask

  initial begin
`ifdef EXEC_SEQ_SKIP_EMPTY_EN
    vecs[0] = '{16'hFFFF, 4, '{0, 1, 2, 3}, '{4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[1] = '{16'h0F00, 1, '{2, 0, 0, 0}, '{4'hF, 0, 0, 0}};
    vecs[2] = '{16'h0000, 1, '{0, 0, 0, 0}, '{4'h0, 0, 0, 0}};
    vecs[3] = '{16'h8001, 2, '{0, 3, 0, 0}, '{4'h1, 4'h8, 0, 0}};
    vecs[4] = '{16'h0520, 2, '{1, 2, 0, 0}, '{4'h2, 4'h5, 0, 0}};
`else
    vecs[0] = '{16'hFFFF, 4, '{0, 1, 2, 3}, '{4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[1] = '{16'h0F00, 4, '{0, 1, 2, 3}, '{4'h0, 4'h0, 4'hF, 4'h0}};
    vecs[2] = '{16'h0000, 4, '{0, 1, 2, 3}, '{4'h0, 4'h0, 4'h0, 4'h0}};
    vecs[3] = '{16'h8001, 4, '{0, 1, 2, 3}, '{4'h1, 4'h0, 4'h0, 4'h8}};
    vecs[4] = '{16'h0520, 4, '{0, 1, 2, 3}, '{4'h0, 4'h2, 4'h5, 4'h0}};
`endif

    // Reset state
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data == '0, 1);
    reset = 1'b0;
    step();

    // Table: one request per vector, out_ready held high
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1;
      in_data  = mk_req(16 + v, vecs[v].tmask);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < vecs[v].n; i++) begin
        chk_pkt(16 + v, vecs[v].pid[i], (i == 0), (i == vecs[v].n - 1), vecs[v].tm[i]);
        chk("in_ready_busy", in_ready, (i == vecs[v].n - 1));
        step();
      end
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);
    end

    // Back-pressure on pid1 for three cycles
    in_valid = 1'b1;
    in_data  = mk_req(40, 16'hFFFF);
    step();
    in_valid = 1'b0;
    chk_pkt(40, 0, 1, 0, 4'hF);
    step();
    chk_pkt(40, 1, 0, 0, 4'hF);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_pkt(40, 1, 0, 0, 4'hF);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk_pkt(40, 2, 0, 0, 4'hF);
    step();
    chk_pkt(40, 3, 0, 1, 4'hF);
    step();
    chk("bp_idle", out_valid, 0);

    // Back-to-back: second request loads on first request's eop handshake
    in_valid = 1'b1;
    in_data  = mk_req(50, 16'hFFFF);
    step();
    in_data  = mk_req(51, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      chk_pkt(50, i, (i == 0), (i == 3), 4'hF);
      chk("b2b_in_ready", in_ready, (i == 3));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_pkt(51, i, (i == 0), (i == 3), 4'hF);
      step();
    end
    chk("b2b_idle", out_valid, 0);

    // Reset while pid1 is pending
    in_valid = 1'b1;
    in_data  = mk_req(60, 16'hFFFF);
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk_pkt(60, 1, 0, 0, 4'hF);
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_quiet", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
